nv_ram_sched: RTL and testbench

Two-requester scheduler in front of the nv_ddre 16x16x8 non-volatile RAM macro.
- Arbitrates read/write requests round-robin.
- Sequences the macro's command protocol: rd_en/wr_en open, command word, close.
- Inserts periodic refresh bursts by dropping power_enable.
- Returns read data on a per-requester response strobe.

---
 rtl/nv_ram_pkg.sv | 49 ++++
 rtl/nv_ram_refresh_timer.sv | 43 ++++
 rtl/nv_ram_sched.sv | 197 +++++++++++++++++++
 tb/tb_nv_ram_sched.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nv_ram_pkg.sv
// Shared definitions for the nv_ddre RAM scheduler slice.
//   state_e      : scheduler FSM states
//   *_BIT/*_MSB  : field positions inside the 18-bit macro command word
//                  {rd, wr, col[3:0], row[3:0], data[7:0]}
//   CLK_MODE_*   : encodings driven on the macro's clk_mode pins
//   make_cmd()   : assembles a command word from its fields
package nv_ram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    OPEN,
    ACCESS,
    CLOSE,
    REFRESH,
    RECOVER
  } state_e;

  localparam int unsigned CMD_W    = 18;
  localparam int unsigned RD_BIT   = 17;
  localparam int unsigned WR_BIT   = 16;
  localparam int unsigned COL_MSB  = 15;
  localparam int unsigned COL_LSB  = 12;
  localparam int unsigned ROW_MSB  = 11;
  localparam int unsigned ROW_LSB  = 8;
  localparam int unsigned DATA_MSB = 7;
  localparam int unsigned DATA_LSB = 0;

  localparam logic [1:0] CLK_MODE_POS = 2'b00;
  localparam logic [1:0] CLK_MODE_NEG = 2'b01;
  localparam logic [1:0] CLK_MODE_DDR = 2'b10;

  function automatic logic [CMD_W-1:0] make_cmd(
    input logic       rd,
    input logic       wr,
    input logic [3:0] col,
    input logic [3:0] row,
    input logic [7:0] data
  );
    logic [CMD_W-1:0] cmd;
    cmd                    = '0;
    cmd[RD_BIT]            = rd;
    cmd[WR_BIT]            = wr;
    cmd[COL_MSB:COL_LSB]   = col;
    cmd[ROW_MSB:ROW_LSB]   = row;
    cmd[DATA_MSB:DATA_LSB] = data;
    return cmd;
  endfunction

endpackage

// File: rtl/nv_ram_refresh_timer.sv
// Free-running refresh interval timer.
//   clk, rst   : clock, asynchronous active-high reset
//   clear_i    : acknowledge, drops the pending flag (refresh burst started)
//   pending_o  : sticky refresh request, set each time the counter hits zero
// The counter runs in every cycle regardless of the scheduler state, so the
// refresh cadence is fixed relative to reset release.
module nv_ram_refresh_timer #(
  parameter int unsigned INTERVAL = 512
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic pending_o
);

  localparam int unsigned    W      = $clog2(INTERVAL);
  localparam logic [W-1:0]   RELOAD = W'(INTERVAL - 1);

  logic [W-1:0] count_q, count_d;
  logic         pending_q, pending_d;
  logic         expire;

  always_comb begin
    expire    = (count_q == '0);
    count_d   = expire ? RELOAD : count_q - W'(1);
    // A fresh expiry wins over a clear in the same cycle; an expiry while
    // already pending simply merges into the outstanding request.
    pending_d = expire | (pending_q & ~clear_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= RELOAD;
      pending_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/nv_ram_sched.sv
// Two-requester round-robin scheduler in front of the nv_ddre 16x16x8
// non-volatile RAM macro.
//   clk, rst          : clock, asynchronous active-high reset
//   req_valid/ready   : per-requester handshake (ready is combinational)
//   req_we/row/col/wdata : per-requester command, requester i in slice i
//   rsp_valid/rdata   : one-cycle read-data strobe per requester, shared data
//   mem_*             : macro control: enable, rd/wr open, power_enable
//                       (low = refresh), clk_mode, 18-bit command word,
//                       read data back from the macro
//   refresh_busy      : high while refreshing or recovering from refresh
// A transaction runs OPEN -> ACCESS -> CLOSE; refresh bursts are inserted
// only from IDLE and have priority over new requests.
module nv_ram_sched
  import nv_ram_pkg::*;
#(
  parameter int unsigned REFRESH_INTERVAL = 512,
  parameter int unsigned REFRESH_CYCLES   = 16,
  parameter logic [1:0]  CLK_MODE         = CLK_MODE_POS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_we,
  input  logic [7:0]  req_row,
  input  logic [7:0]  req_col,
  input  logic [15:0] req_wdata,
  output logic [1:0]  rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        mem_enable,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic        mem_power_enable,
  output logic [1:0]  mem_clk_mode,
  output logic [17:0] mem_user_data,
  input  logic [7:0]  mem_user_out,
  output logic        refresh_busy
);

  localparam logic [7:0] RCNT_LOAD = 8'(REFRESH_CYCLES - 1);

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             gnt_q, gnt_d;
  logic             we_q, we_d;
  logic [3:0]       row_q, row_d;
  logic [3:0]       col_q, col_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rcnt_q, rcnt_d;

  logic             mem_enable_q;
  logic             rd_en_q, rd_en_d;
  logic             wr_en_q, wr_en_d;
  logic [CMD_W-1:0] user_data_q, user_data_d;
  logic             power_q, power_d;
  logic             busy_q, busy_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_rdata_q, rsp_rdata_d;

  logic             refresh_pending;
  logic             refresh_clear;
  logic             sel;
  logic [7:0]       data_f;

  nv_ram_refresh_timer #(
    .INTERVAL (REFRESH_INTERVAL)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (refresh_clear),
    .pending_o (refresh_pending)
  );

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    gnt_d         = gnt_q;
    we_d          = we_q;
    row_d         = row_q;
    col_d         = col_q;
    wdata_d       = wdata_q;
    rcnt_d        = rcnt_q;
    req_ready     = '0;
    rsp_valid_d   = '0;
    rsp_rdata_d   = rsp_rdata_q;
    refresh_clear = 1'b0;
    sel           = 1'b0;

    case (state_q)
      IDLE: begin
        if (refresh_pending) begin
          state_d       = REFRESH;
          refresh_clear = 1'b1;
          rcnt_d        = RCNT_LOAD;
        end else if (req_valid != 2'b00) begin
          // Contention goes to whoever did not win last; otherwise the
          // single valid requester.
          sel            = (req_valid == 2'b11) ? ~last_q : req_valid[1];
          req_ready[sel] = ~rst;
          gnt_d          = sel;
          last_d         = sel;
          we_d           = req_we[sel];
          row_d          = req_row[{sel, 2'b00} +: 4];
          col_d          = req_col[{sel, 2'b00} +: 4];
          wdata_d        = req_wdata[{sel, 3'b000} +: 8];
          state_d        = OPEN;
        end
      end
      OPEN:   state_d = ACCESS;
      ACCESS: state_d = CLOSE;
      CLOSE: begin
        state_d = IDLE;
        if (!we_q) begin
          rsp_valid_d[gnt_q] = 1'b1;
          rsp_rdata_d        = mem_user_out;
        end
      end
      REFRESH: begin
        if (rcnt_q == '0) begin
          state_d = RECOVER;
        end else begin
          rcnt_d = rcnt_q - 8'd1;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Macro pins are registered: each is computed from the state being
    // entered so it is valid for the whole of that state.
    data_f      = we_d ? wdata_d : '0;
    rd_en_d     = 1'b0;
    wr_en_d     = 1'b0;
    user_data_d = '0;
    case (state_d)
      OPEN: begin
        wr_en_d     = we_d;
        rd_en_d     = ~we_d;
        user_data_d = make_cmd(1'b0, 1'b0, col_d, row_d, data_f);
      end
      ACCESS: user_data_d = make_cmd(~we_d, we_d, col_d, row_d, data_f);
      CLOSE:  user_data_d = make_cmd(1'b0, 1'b0, col_d, row_d, data_f);
      default: ;
    endcase
    power_d = (state_d != REFRESH);
    busy_d  = (state_d == REFRESH) || (state_d == RECOVER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      wdata_q      <= '0;
      rcnt_q       <= '0;
      mem_enable_q <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      user_data_q  <= '0;
      power_q      <= 1'b1;
      busy_q       <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      gnt_q        <= gnt_d;
      we_q         <= we_d;
      row_q        <= row_d;
      col_q        <= col_d;
      wdata_q      <= wdata_d;
      rcnt_q       <= rcnt_d;
      mem_enable_q <= 1'b1;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      user_data_q  <= user_data_d;
      power_q      <= power_d;
      busy_q       <= busy_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  assign mem_enable       = mem_enable_q;
  assign mem_rd_en        = rd_en_q;
  assign mem_wr_en        = wr_en_q;
  assign mem_user_data    = user_data_q;
  assign mem_power_enable = power_q;
  assign mem_clk_mode     = CLK_MODE;
  assign refresh_busy     = busy_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_rdata        = rsp_rdata_q;

endmodule

// File: tb/tb_nv_ram_sched.sv
// Self-checking bench for nv_ram_sched with a simple macro model that stores
// on write commands and returns data one cycle after a read command.
module tb_nv_ram_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid, mem_clk_mode;
  logic [7:0]  req_row, req_col, rsp_rdata, mem_user_out;
  logic [15:0] req_wdata;
  logic        mem_enable, mem_rd_en, mem_wr_en, mem_power_enable, refresh_busy;
  logic [17:0] mem_user_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] mac [256];
  logic [7:0] ref_mem [256];
  logic       mac_init = 1'b0;

  always #5 clk = ~clk;

  nv_ram_sched #(
    .REFRESH_INTERVAL (64),
    .REFRESH_CYCLES   (16),
    .CLK_MODE         (2'b10)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_we           (req_we),
    .req_row          (req_row),
    .req_col          (req_col),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_rdata        (rsp_rdata),
    .mem_enable       (mem_enable),
    .mem_rd_en        (mem_rd_en),
    .mem_wr_en        (mem_wr_en),
    .mem_power_enable (mem_power_enable),
    .mem_clk_mode     (mem_clk_mode),
    .mem_user_data    (mem_user_data),
    .mem_user_out     (mem_user_out),
    .refresh_busy     (refresh_busy)
  );

  // Macro model, indexed {row,col}.
  always @(posedge clk) begin
    if (!mac_init) begin
      for (int i = 0; i < 256; i++) mac[i] <= 8'(i * 37 + 11);
      mac_init     <= 1'b1;
      mem_user_out <= '0;
    end else begin
      if (mem_user_data[16]) mac[{mem_user_data[11:8], mem_user_data[15:12]}] <= mem_user_data[7:0];
      if (mem_user_data[17]) mem_user_out <= mac[{mem_user_data[11:8], mem_user_data[15:12]}];
    end
  end

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_we = '0; req_row = '0; req_col = '0; req_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [3:0] row,
                         input logic [3:0] col, input logic [7:0] d);
    req_we[i]          = we;
    req_row[i*4 +: 4]  = row;
    req_col[i*4 +: 4]  = col;
    req_wdata[i*8 +: 8] = d;
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    req_valid = 2'b11;
    #1;
    obs = {mem_enable, req_ready, rsp_valid, mem_rd_en, mem_wr_en, mem_power_enable, refresh_busy};
    checks++; if (obs !== 9'b000000010) begin errors++; $display("FAIL reset_ctrl got=%b exp=000000010", obs); end
    checks++; if (mem_user_data !== 18'h0) begin errors++; $display("FAIL reset_user_data got=%h exp=0", mem_user_data); end
    checks++; if (rsp_rdata !== 8'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata); end
    checks++; if (mem_clk_mode !== 2'b10) begin errors++; $display("FAIL clk_mode got=%b exp=10", mem_clk_mode); end
    @(negedge clk);
    req_valid = '0;
    rst = 1'b0;
    cyc = 0;
    checks++; if (mem_enable !== 1'b0) begin errors++; $display("FAIL enable_c0 got=%b exp=0", mem_enable); end
    step();
    checks++; if (mem_enable !== 1'b1) begin errors++; $display("FAIL enable_c1 got=%b exp=1", mem_enable); end
  endtask

  task automatic test_write_read();
    do_reset();
    set_req(0, 1'b1, 4'd3, 4'd5, 8'hA5);
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL wr_accept got=%b exp=01", req_ready); end
    ref_mem[{4'd3, 4'd5}] = 8'hA5;
    step(); req_valid = '0;
    checks++; if ({mem_wr_en, mem_rd_en, mem_user_data} !== {2'b10, 18'h053A5}) begin errors++; $display("FAIL wr_open got=%b%b %h exp=10 053a5", mem_wr_en, mem_rd_en, mem_user_data); end
    step();
    checks++; if ({mem_wr_en, mem_rd_en, mem_user_data} !== {2'b00, 18'h153A5}) begin errors++; $display("FAIL wr_access got=%b%b %h exp=00 153a5", mem_wr_en, mem_rd_en, mem_user_data); end
    step();
    checks++; if (mem_user_data !== 18'h053A5) begin errors++; $display("FAIL wr_close got=%h exp=053a5", mem_user_data); end
    step();
    checks++; if ({rsp_valid, mem_user_data} !== 20'h0) begin errors++; $display("FAIL wr_idle got=%b %h exp=00 0", rsp_valid, mem_user_data); end
    set_req(0, 1'b0, 4'd3, 4'd5, 8'h00);
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rd_accept got=%b exp=01", req_ready); end
    step(); req_valid = '0;
    checks++; if ({mem_wr_en, mem_rd_en, mem_user_data} !== {2'b01, 18'h05300}) begin errors++; $display("FAIL rd_open got=%b%b %h exp=01 05300", mem_wr_en, mem_rd_en, mem_user_data); end
    step();
    checks++; if (mem_user_data !== 18'h25300) begin errors++; $display("FAIL rd_access got=%h exp=25300", mem_user_data); end
    step();
    checks++; if ({rsp_valid, mem_user_data} !== {2'b00, 18'h05300}) begin errors++; $display("FAIL rd_close got=%b %h exp=00 05300", rsp_valid, mem_user_data); end
    step();
    checks++; if ({rsp_valid, rsp_rdata} !== {2'b01, 8'hA5}) begin errors++; $display("FAIL rd_rsp got=%b %h exp=01 a5", rsp_valid, rsp_rdata); end
    step();
    checks++; if ({rsp_valid, rsp_rdata} !== {2'b00, 8'hA5}) begin errors++; $display("FAIL rd_hold got=%b %h exp=00 a5", rsp_valid, rsp_rdata); end
  endtask

  task automatic test_contention();
    int g, prev;
    logic [1:0] exp_rdy, exp_rsp;
    logic [7:0] exp_d;
    do_reset();
    set_req(0, 1'b0, 4'd1, 4'd2, 8'h00);
    set_req(1, 1'b0, 4'd4, 4'd9, 8'h00);
    req_valid = 2'b11;
    g = 0; prev = -1;
    for (int c = 0; c <= 16; c++) begin
      #1;
      exp_rdy = (c % 4 == 0) ? ((g == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_rsp = (c % 4 == 0 && prev >= 0) ? ((prev == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_d   = (prev == 0) ? ref_mem[{4'd1, 4'd2}] : ref_mem[{4'd4, 4'd9}];
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL cont_ready c=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
      checks++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL cont_rsp c=%0d got=%b exp=%b", c, rsp_valid, exp_rsp); end
      if (exp_rsp != 2'b00) begin
        checks++; if (rsp_rdata !== exp_d) begin errors++; $display("FAIL cont_data c=%0d got=%h exp=%h", c, rsp_rdata, exp_d); end
      end
      if (c % 4 == 0) begin prev = g; g = 1 - g; end
      step();
    end
    req_valid = '0;
  endtask

  task automatic test_refresh_idle();
    logic lo, bz;
    int busy_cnt;
    do_reset();
    busy_cnt = 0;
    for (int c = 0; c <= 200; c++) begin
      lo = (c >= 65) && ((c - 65) % 64 < 16);
      bz = (c >= 65) && ((c - 65) % 64 < 17);
      if (c <= 100 && refresh_busy === 1'b1) busy_cnt++;
      checks++; if (mem_power_enable !== !lo) begin errors++; $display("FAIL ref_power c=%0d got=%b exp=%b", c, mem_power_enable, !lo); end
      checks++; if (refresh_busy !== bz) begin errors++; $display("FAIL ref_busy c=%0d got=%b exp=%b", c, refresh_busy, bz); end
      checks++; if ({mem_rd_en, mem_wr_en, mem_user_data} !== 20'h0) begin errors++; $display("FAIL ref_quiet c=%0d got=%b%b %h exp=0", c, mem_rd_en, mem_wr_en, mem_user_data); end
      step();
    end
    checks++; if (busy_cnt != 17) begin errors++; $display("FAIL ref_busy_len got=%0d exp=17", busy_cnt); end
  endtask

  task automatic test_refresh_vs_traffic();
    logic [1:0] exp_rdy, exp_rsp;
    do_reset();
    while (cyc < 61) step();
    set_req(1, 1'b0, 4'd7, 4'd1, 8'h00);
    req_valid = 2'b10;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rvt_accept got=%b exp=10", req_ready); end
    step(); req_valid = '0;
    for (int c = 62; c <= 83; c++) begin
      if (c == 65) begin set_req(0, 1'b0, 4'd2, 4'd3, 8'h00); req_valid = 2'b01; end
      #1;
      exp_rdy = (c == 83) ? 2'b01 : 2'b00;
      exp_rsp = (c == 65) ? 2'b10 : 2'b00;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rvt_ready c=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
      checks++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL rvt_rsp c=%0d got=%b exp=%b", c, rsp_valid, exp_rsp); end
      if (c == 65) begin
        checks++; if (rsp_rdata !== ref_mem[{4'd7, 4'd1}]) begin errors++; $display("FAIL rvt_data got=%h exp=%h", rsp_rdata, ref_mem[{4'd7, 4'd1}]); end
      end
      checks++; if (mem_power_enable !== !(c >= 66 && c <= 81)) begin errors++; $display("FAIL rvt_power c=%0d got=%b", c, mem_power_enable); end
      checks++; if (refresh_busy !== (c >= 66 && c <= 82)) begin errors++; $display("FAIL rvt_busy c=%0d got=%b", c, refresh_busy); end
      step();
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_read();
    logic [8:0] obs;
    logic [1:0] exp_rsp;
    do_reset();
    set_req(0, 1'b0, 4'd2, 4'd2, 8'h00);
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rmr_accept got=%b exp=01", req_ready); end
    step(); req_valid = '0;
    step();
    rst = 1'b1;
    #1;
    obs = {mem_enable, req_ready, rsp_valid, mem_rd_en, mem_wr_en, mem_power_enable, refresh_busy};
    checks++; if (obs !== 9'b000000010) begin errors++; $display("FAIL rmr_ctrl got=%b exp=000000010", obs); end
    checks++; if ({mem_user_data, rsp_rdata} !== 26'h0) begin errors++; $display("FAIL rmr_data got=%h %h exp=0 0", mem_user_data, rsp_rdata); end
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    for (int c = 0; c <= 6; c++) begin
      if (c == 2) begin
        set_req(0, 1'b0, 4'd5, 4'd5, 8'h00);
        set_req(1, 1'b0, 4'd6, 4'd6, 8'h00);
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rmr_first_grant got=%b exp=01", req_ready); end
      end
      exp_rsp = (c == 6) ? 2'b01 : 2'b00;
      checks++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL rmr_rsp c=%0d got=%b exp=%b", c, rsp_valid, exp_rsp); end
      if (c == 6) begin
        checks++; if (rsp_rdata !== ref_mem[{4'd5, 4'd5}]) begin errors++; $display("FAIL rmr_data2 got=%h exp=%h", rsp_rdata, ref_mem[{4'd5, 4'd5}]); end
      end
      step();
      req_valid = '0;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] row [4];
    logic [3:0] col [4];
    logic [7:0] d;
    logic [1:0] exp_rdy, exp_rsp;
    int k;
    do_reset();
    for (int i = 0; i < 4; i++) begin row[i] = 4'(i * 3 + 1); col[i] = 4'(15 - i); end
    for (int c = 0; c <= 32; c++) begin
      k = c / 4;
      if (c % 4 == 0) begin
        if (k < 4) begin
          d = 8'($urandom);
          set_req(1, 1'b1, row[k], col[k], d);
          req_valid = 2'b10;
        end else if (k < 8) begin
          set_req(1, 1'b0, row[k-4], col[k-4], 8'h00);
          req_valid = 2'b10;
        end else begin
          req_valid = '0;
        end
      end
      #1;
      exp_rdy = (c % 4 == 0 && k < 8) ? 2'b10 : 2'b00;
      exp_rsp = (c % 4 == 0 && k >= 5) ? 2'b10 : 2'b00;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
      checks++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL b2b_rsp c=%0d got=%b exp=%b", c, rsp_valid, exp_rsp); end
      if (exp_rsp != 2'b00) begin
        checks++; if (rsp_rdata !== ref_mem[{row[k-5], col[k-5]}]) begin errors++; $display("FAIL b2b_data c=%0d got=%h exp=%h", c, rsp_rdata, ref_mem[{row[k-5], col[k-5]}]); end
      end
      if (c % 4 == 0 && k < 4) ref_mem[{row[k], col[k]}] = d;
      step();
    end
    req_valid = '0;
  endtask

  // Transaction-level model: fixed 4-cycle occupancy per access, refresh
  // requests every 64 cycles from reset taken at the next free slot for
  // 16 low cycles plus one recovery cycle, round-robin on contention.
  task automatic test_random();
    int next_free, ref_start, rsp_at, g;
    logic pending, last;
    logic [1:0] v, exp_rdy, exp_rsp, rsp_who;
    logic [7:0] rsp_d;
    logic [3:0] r, cl;
    logic lo, bz;
    do_reset();
    next_free = 0; ref_start = -100; rsp_at = -1; pending = 1'b0; last = 1'b1;
    rsp_who = 2'b00; rsp_d = '0;
    for (int c = 0; c < 500; c++) begin
      lo = (c >= ref_start + 1) && (c <= ref_start + 16);
      bz = (c >= ref_start + 1) && (c <= ref_start + 17);
      exp_rsp = (c == rsp_at) ? rsp_who : 2'b00;
      checks++; if (mem_power_enable !== !lo) begin errors++; $display("FAIL rand_power c=%0d got=%b exp=%b", c, mem_power_enable, !lo); end
      checks++; if (refresh_busy !== bz) begin errors++; $display("FAIL rand_busy c=%0d got=%b exp=%b", c, refresh_busy, bz); end
      checks++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL rand_rsp c=%0d got=%b exp=%b", c, rsp_valid, exp_rsp); end
      if (exp_rsp != 2'b00) begin
        checks++; if (rsp_rdata !== rsp_d) begin errors++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, rsp_rdata, rsp_d); end
      end
      if (c > 0 && c % 64 == 0) pending = 1'b1;
      v = 2'($urandom_range(0, 3));
      req_valid = v;
      req_we = 2'($urandom);
      req_row = 8'($urandom); req_col = 8'($urandom); req_wdata = 16'($urandom);
      #1;
      exp_rdy = 2'b00;
      if (c >= next_free) begin
        if (pending) begin
          pending = 1'b0; ref_start = c; next_free = c + 18;
        end else if (v != 2'b00) begin
          g = (v == 2'b11) ? int'(!last) : int'(v == 2'b10);
          exp_rdy = (g == 0) ? 2'b01 : 2'b10;
          last = (g == 1);
          next_free = c + 4;
          r  = req_row[g*4 +: 4];
          cl = req_col[g*4 +: 4];
          if (req_we[g]) ref_mem[{r, cl}] = req_wdata[g*8 +: 8];
          else begin rsp_at = c + 4; rsp_who = exp_rdy; rsp_d = ref_mem[{r, cl}]; end
        end
      end
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);
    test_reset();
    test_write_read();
    test_contention();
    test_refresh_idle();
    test_refresh_vs_traffic();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
